// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Upstream stage of the 8-bit multicycle MIPS core. The block owns the shared
// memory port from power-up. It accepts a byte stream and writes it to
// consecutive addresses starting at START_ADR, holding the core in reset
// meanwhile. After the last byte it releases the core and becomes a zero-latency
// pass-through for the core's memory interface.
//
// Optional feature (compile-time macro): BOOT_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the LOAD_BYTES data bytes. It must
//   equal the 8-bit running sum of the data bytes. A mismatch parks the block
//   in ERROR (err=1, core held in reset) until rst. When undefined, no checksum
//   byte is expected and err is tied low.
//
// Handshake: a byte moves when in_valid and in_ready are both high in the same
// cycle. in_ready depends only on state. in_valid may rise or fall at any time;
// data is sampled only on the handshake edge.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, in_data         loader byte stream (in)
//   in_ready                  loader can accept a byte (out)
//   cpu_adr, cpu_writedata,   core memory interface (in)
//   cpu_memread, cpu_memwrite
//   mem_adr, mem_writedata,   memory port (out)
//   mem_memread, mem_memwrite
//   cpu_rst                   registered reset to the core (out)
//   done                      load complete, core running (out)
//   err                       checksum mismatch (out, checksum build only)
//
// The FSM state is visible as the internal signal 'state' (type state_t).
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int          WIDTH      = 8,
  parameter int          LOAD_BYTES = 64,
  parameter int unsigned START_ADR  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_writedata,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  // Counter is wide enough to hold LOAD_BYTES itself, which the checksum
  // build needs to recognise the checksum byte.
  localparam int            CW       = $clog2(LOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LOAD_BYTES - 1);
  localparam logic [CW-1:0] SUM_CNT  = CW'(LOAD_BYTES);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,S_ERROR = 2'd3
`endif
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] wr_adr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             hs;       // handshake this cycle
  logic             data_hs;  // handshake carrying a byte to be written

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_q;
  logic       is_sum_byte;
`endif

  assign hs = in_valid & in_ready;

`ifdef BOOT_LOADER_CHECKSUM_EN
  // The handshake after LOAD_BYTES data bytes carries the checksum.
  assign is_sum_byte = (cnt == SUM_CNT);
  assign data_hs     = hs & ~is_sum_byte;
  assign err         = err_q;
`else
  assign data_hs     = hs;
  assign err         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (hs && is_sum_byte)
          state_next = (8'(in_data) == sum) ? S_DRAIN : S_ERROR;
`else
        if (hs && (cnt == LAST_CNT))
          state_next = S_DRAIN;
`endif
      end
      S_DRAIN: state_next = S_RUN;
      default: state_next = state;  // RUN (and ERROR) hold until rst
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Outside RUN the memory port is driven from the write
  // register; wr_en is only ever set by a data handshake, so DRAIN carries the
  // final byte and ERROR issues nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready      = (state == S_LOAD);
    mem_adr       = wr_adr;
    mem_writedata = wr_data;
    mem_memwrite  = wr_en;
    mem_memread   = 1'b0;
    if (state == S_RUN) begin
      mem_adr       = cpu_adr;
      mem_writedata = cpu_writedata;
      mem_memwrite  = cpu_memwrite;
      mem_memread   = cpu_memread;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      wr_adr  <= WIDTH'(START_ADR);
      wr_data <= '0;
      wr_en   <= 1'b0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
    end else begin
      wr_en <= data_hs;
      if (data_hs) begin
        // Address wraps modulo 2**WIDTH.
        wr_adr  <= WIDTH'(START_ADR) + WIDTH'(cnt);
        wr_data <= in_data;
        cnt     <= cnt + CW'(1);
      end
      // Leaving DRAIN releases the core and flags completion on the same edge.
      if (state == S_DRAIN) begin
        cpu_rst <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (data_hs)
        sum <= sum + 8'(in_data);
      if (state_next == S_ERROR)
        err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Bench for boot_loader with LOAD_BYTES=4 and START_ADR=8'hFE, so every load
// wraps the address space. A behavioural model tracks how many bytes have been
// accepted since reset and which phase of the load sequence applies, keeps the
// expected memory writes in a queue, and is compared against the DUT on every
// negative edge. Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  localparam int W  = 8;
  localparam int LB = 4;
  localparam int SA = 'hFE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] cpu_adr;
  logic [W-1:0] cpu_writedata;
  logic         cpu_memread;
  logic         cpu_memwrite;
  logic [W-1:0] mem_adr;
  logic [W-1:0] mem_writedata;
  logic         mem_memread;
  logic         mem_memwrite;
  logic         cpu_rst;
  logic         done;
  logic         err;

  int n_vec = 0;
  int n_err = 0;

  boot_loader #(
    .WIDTH     (W),
    .LOAD_BYTES(LB),
    .START_ADR (SA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cpu_adr      (cpu_adr),
    .cpu_writedata(cpu_writedata),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .mem_adr      (mem_adr),
    .mem_writedata(mem_writedata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int              m_acc;      // data bytes accepted since reset
  bit              m_loading;  // accepting bytes
  bit              m_drain;    // one cycle between last byte and release
  bit              m_running;  // core released
  bit              m_failed;   // checksum mismatch seen
  bit              m_wr_now;   // a write must appear this cycle
  bit              m_fresh;    // no handshake since reset
  logic [7:0]      m_sum;
  logic [2*W-1:0]  exp_q[$];   // {adr, data} of expected writes

  always @(posedge clk) begin
    logic [W-1:0] a;
    if (rst) begin
      m_acc = 0; m_loading = 1; m_drain = 0; m_running = 0; m_failed = 0;
      m_wr_now = 0; m_fresh = 1; m_sum = 0;
      exp_q.delete();
    end else begin
      m_wr_now = 0;
      if (m_drain) begin
        m_drain   = 0;
        m_running = 1;
      end else if (m_loading && in_valid) begin
        m_fresh = 0;
        if (m_acc < LB) begin
          a = W'(SA + m_acc);
          exp_q.push_back({a, in_data});
          m_wr_now = 1;
          m_sum    = m_sum + in_data;
          m_acc++;
`ifndef BOOT_LOADER_CHECKSUM_EN
          if (m_acc == LB) begin
            m_loading = 0;
            m_drain   = 1;
          end
`endif
        end else begin
          m_loading = 0;
          if (in_data == m_sum) m_drain = 1;
          else                  m_failed = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: every cycle, away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    chk("in_ready", in_ready, m_loading);
    chk("cpu_rst",  cpu_rst,  !m_running);
    chk("done",     done,     m_running);
    chk("err",      err,      m_failed);
    chk("memread",  mem_memread,  m_running ? cpu_memread  : 1'b0);
    chk("memwrite", mem_memwrite, m_running ? cpu_memwrite : m_wr_now);
    if (m_running) begin
      chk("pass_adr",   mem_adr,       cpu_adr);
      chk("pass_wdata", mem_writedata, cpu_writedata);
    end else if (m_wr_now) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr",  mem_adr,       e[2*W-1:W]);
        chk("wr_data", mem_writedata, e[W-1:0]);
      end
    end else if (m_fresh) begin
      chk("rst_adr",   mem_adr,       SA);
      chk("rst_wdata", mem_writedata, 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: apply inputs just after a rising edge, return at the falling edge
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    rst           = r;
    in_valid      = v;
    in_data       = d;
    cpu_adr       = W'($urandom);
    cpu_writedata = W'($urandom);
    cpu_memread   = 1'($urandom_range(0, 1));
    cpu_memwrite  = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic load4(input logic [W-1:0] b0, input logic [W-1:0] b1,
                       input logic [W-1:0] b2, input logic [W-1:0] b3);
    cyc(0, 1, b0); cyc(0, 1, b1); cyc(0, 1, b2); cyc(0, 1, b3);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int dens;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cpu_adr = '0; cpu_writedata = '0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;

    // Reset state
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h5A);
    chk("lit_rst_cpu_rst",  cpu_rst, 1);
    chk("lit_rst_in_ready", in_ready, 1);
    chk("lit_rst_done",     done, 0);
    chk("lit_rst_err",      err, 0);
    chk("lit_rst_memwrite", mem_memwrite, 0);
    chk("lit_rst_memread",  mem_memread, 0);
    chk("lit_rst_adr",      mem_adr, 8'hFE);

    // Contiguous load with wrap: writes (FE,A1)(FF,A2)(00,A3)(01,A4)
    cyc(0, 1, 8'hA1);
    chk("lit_c_first_nowrite", mem_memwrite, 0);
    cyc(0, 1, 8'hA2);
    chk("lit_c_w0_adr", mem_adr, 8'hFE); chk("lit_c_w0_data", mem_writedata, 8'hA1);
    cyc(0, 1, 8'hA3);
    chk("lit_c_w1_adr", mem_adr, 8'hFF); chk("lit_c_w1_data", mem_writedata, 8'hA2);
    cyc(0, 1, 8'hA4);
    chk("lit_c_w2_adr", mem_adr, 8'h00); chk("lit_c_w2_data", mem_writedata, 8'hA3);
`ifdef BOOT_LOADER_CHECKSUM_EN
    cyc(0, 1, 8'h8A);  // A1+A2+A3+A4 = 0x28A
`else
    cyc(0, 0, 8'h00);
    chk("lit_c_drain_ready", in_ready, 0);
`endif
    chk("lit_c_w3_we",   mem_memwrite, 1);
    chk("lit_c_w3_adr",  mem_adr, 8'h01);
    chk("lit_c_w3_data", mem_writedata, 8'hA4);
    chk("lit_c_hold_rst", cpu_rst, 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    cyc(0, 0, 8'h00);
`endif
    cyc(0, 0, 8'h00);
    chk("lit_c_cpu_rst", cpu_rst, 0);
    chk("lit_c_done",    done, 1);
    chk("lit_c_ready",   in_ready, 0);

    // Pass-through in RUN; loader input ignored
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'hFF;
    cpu_adr = 8'h20; cpu_writedata = 8'h55; cpu_memwrite = 1; cpu_memread = 0;
    @(negedge clk);
    chk("lit_p_adr",   mem_adr, 8'h20);
    chk("lit_p_wdata", mem_writedata, 8'h55);
    chk("lit_p_we",    mem_memwrite, 1);
    chk("lit_p_ready", in_ready, 0);
    #2;
    cpu_adr = 8'h21; cpu_memwrite = 0; cpu_memread = 1;
    #1;
    chk("lit_p_adr2", mem_adr, 8'h21);
    chk("lit_p_re2",  mem_memread, 1);
    chk("lit_p_we2",  mem_memwrite, 0);

    // Reset mid-load; rst beats a simultaneous handshake
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    cyc(1, 1, 8'h33);
    cyc(0, 1, 8'h77);
    chk("lit_r_discard", mem_memwrite, 0);
    cyc(0, 1, 8'h88);
    chk("lit_r_w_adr",  mem_adr, 8'hFE);
    chk("lit_r_w_data", mem_writedata, 8'h77);
    cyc(0, 1, 8'h99);
    cyc(0, 0, 8'h00);
    chk("lit_r_still_loading", in_ready, 1);
    chk("lit_r_still_rst",     cpu_rst, 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Good checksum
    cyc(1, 0, 8'h00);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    cyc(0, 1, 8'h0A);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    chk("lit_cs_ok_done", done, 1);
    chk("lit_cs_ok_err",  err, 0);
    // Bad checksum
    cyc(1, 0, 8'h00);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    cyc(0, 1, 8'h0B);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h00);
    chk("lit_cs_bad_err",   err, 1);
    chk("lit_cs_bad_rst",   cpu_rst, 1);
    chk("lit_cs_bad_ready", in_ready, 0);
    chk("lit_cs_bad_we",    mem_memwrite, 0);
`endif

    // Randomized loads: varying stream density, occasional reset
    for (int l = 0; l < 16; l++) begin
      dens = $urandom_range(20, 100);
      cyc(1, 0, 8'h00);
      for (int c = 0; c < 150 && !m_running && !m_failed; c++)
        cyc($urandom_range(0, 39) == 0, $urandom_range(1, 100) <= dens, W'($urandom));
      for (int c = 0; c < 8; c++)
        cyc(0, 1'($urandom_range(0, 1)), W'($urandom));
    end

    cyc(0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream stage of the 8-bit multicycle MIPS core. It owns the shared memory port at power-up.
- It accepts a byte stream over a valid/ready handshake and writes the bytes into consecutive memory addresses. The core is held in reset while this happens.
- After the last byte it releases the core and becomes a transparent pass-through for the core's memory interface (adr, writedata, memread, memwrite).

Parameters:
- WIDTH, 8: data and address width; matches the core's WIDTH.
- LOAD_BYTES, 64: number of program bytes to load. Legal range is 1..2**WIDTH.
- START_ADR, 0: memory address of the first loaded byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  loader byte is valid.
- in_data  input  WIDTH  loader byte.
- in_ready  output  1  loader can accept a byte.
- cpu_adr  input  WIDTH  core memory address.
- cpu_writedata  input  WIDTH  core write data.
- cpu_memread  input  1  core read strobe.
- cpu_memwrite  input  1  core write strobe.
- mem_adr  output  WIDTH  address to memory.
- mem_writedata  output  WIDTH  write data to memory.
- mem_memread  output  1  read strobe to memory.
- mem_memwrite  output  1  write strobe to memory.
- cpu_rst  output  1  reset to the core; active-high, registered.
- done  output  1  load complete; core running.
- err  output  1  load failed (checksum option only).

Behaviour:
- Interface (already decided): one clock, clk; rst is synchronous and active-high.
- Reset values:
  - state=LOAD, byte count cnt=0, write register empty.
  - cpu_rst=1, in_ready=1, done=0, err=0.
  - mem_memwrite=0, mem_memread=0, mem_adr=START_ADR, mem_writedata=0.
- States: LOAD -> DRAIN -> RUN. A fourth state, ERROR, exists only with the option below.
- LOAD:
  - in_ready=1, decoded combinationally from state.
  - Handshake is in_valid & in_ready in a cycle.
  - On a handshake the block registers wr_adr=(START_ADR+cnt) mod 2**WIDTH and wr_data=in_data, sets wr_en=1, and increments cnt.
  - The write appears on mem_* in the cycle after the handshake (latency 1). It lasts exactly one cycle unless another handshake occurs back-to-back.
  - One byte per cycle is sustained.
  - Cycles with in_valid=0 produce mem_memwrite=0.
  - mem_memread=0 throughout LOAD and DRAIN.
- LOAD -> DRAIN: on the handshake where cnt==LOAD_BYTES-1. The counter is wide enough to hold LOAD_BYTES.
- DRAIN:
  - in_ready=0; the final registered write is issued on mem_*.
  - The next edge moves to RUN and clears cpu_rst.
  - As a result, cpu_rst falls exactly 2 cycles after the last handshake.
- RUN:
  - mem_adr, mem_writedata, mem_memread and mem_memwrite equal the cpu_* inputs combinationally, with zero latency.
  - in_ready=0; in_valid and in_data are ignored.
  - done=1, registered and set on the same edge that clears cpu_rst.
  - RUN is held until rst.
- Address arithmetic wraps modulo 2**WIDTH; there is no overflow flag.
- Core signals are ignored outside RUN.
- rst in any state, including mid-load or during DRAIN, returns all state to the reset values on the next edge. A pending registered write is discarded, and the next load restarts at START_ADR.
- When rst and a handshake occur in the same cycle, rst wins and no write is issued.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) accumulates every loaded byte.
  - After LOAD_BYTES data bytes, the block stays in LOAD for one extra handshake that carries a checksum byte. That byte is not written to memory.
  - If the checksum byte equals the sum, the block goes to DRAIN, then RUN.
  - Otherwise it goes to ERROR: err=1, cpu_rst held at 1, in_ready=0, no memory writes, left only by rst.
  - The sum clears on rst.
- When undefined: no checksum byte is expected, err is tied to 0, and the ERROR state does not exist.

Test Plan:
- Reset check: assert rst for 2 cycles -> cpu_rst=1, in_ready=1, done=0, err=0, mem_memwrite=0, mem_memread=0.
- Contiguous load (LOAD_BYTES=4, START_ADR=8'h10): bytes A1,A2,A3,A4 on consecutive cycles -> writes (10,A1)(11,A2)(12,A3)(13,A4), each one cycle after its handshake. cpu_rst falls 2 cycles after A4 is accepted, done=1, in_ready=0.
- Gappy stream and wrap (START_ADR=8'hFE, LOAD_BYTES=4): in_valid toggles 1,0,1,0,... -> writes at FE, FF, 00, 01 only in cycles following handshakes; mem_memwrite=0 in the gap cycles.
- RUN pass-through: cpu_adr=20, cpu_writedata=55, cpu_memwrite=1 -> same-cycle mem_adr=20, mem_writedata=55, mem_memwrite=1. in_valid=1 with in_data=FF produces no effect.
- Reset mid-load: accept 2 bytes, pulse rst, send byte 77 -> 77 written at START_ADR; cnt restarted, so LOAD_BYTES more bytes are needed before release.
- BOOT_LOADER_CHECKSUM_EN, LOAD_BYTES=4:
  - Bytes 01,02,03,04 then checksum 0A -> RUN, err=0.
  - Same bytes then checksum 0B -> err=1, cpu_rst stays 1, only 4 writes seen.
